// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, state encoding and BCD helpers for the scoreboard
package score_pkg;

   // Active-low 7-segment patterns, bit order gfedcba
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      PLAY       = 1'b0,
      MATCH_OVER = 1'b1
   } state_t;

   // One BCD digit plus carry-in; returns {carry_out, digit}
   function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
      if (!cin)
         return {1'b0, digit};
      if (digit >= 4'd9)
         return {1'b1, 4'd0};
      return {1'b0, digit + 4'd1};
   endfunction

   // Elaboration-time conversion of an integer to up to 8 packed BCD digits
   function automatic logic [31:0] to_bcd(input int value);
      logic [31:0] r;
      int          t;
      r = '0;
      t = value;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_board_if.sv
// rtl/score_board_if.sv - round-result inputs and score/display outputs of the scoreboard
interface score_board_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int DIGITS      = 2
);
   localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

   logic                            round_done;
   logic [PW-1:0]                   round_winner;
   logic                            round_draw;
   logic                            new_match;
   logic [NUM_PLAYERS*DIGITS*4-1:0] scores_bcd;
   logic [NUM_PLAYERS*DIGITS*7-1:0] hex_out;
   logic                            score_changed;
   logic                            match_over;
   logic [PW-1:0]                   match_winner;

   // Game logic side: reports round results, observes scores
   modport master (
      output round_done, round_winner, round_draw, new_match,
      input  scores_bcd, hex_out, score_changed, match_over, match_winner
   );

   // Scoreboard side
   modport slave (
      input  round_done, round_winner, round_draw, new_match,
      output scores_bcd, hex_out, score_changed, match_over, match_winner
   );
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - one BCD digit to an active-low 7-segment pattern
import score_pkg::*;

module seg7_decoder (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Codes 10-15 cannot occur in a score register; they show "0"
   always_comb begin
      seg = SEG_0;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/score_board.sv
// rtl/score_board.sv - multi-player BCD match scoreboard with match-end detection
import score_pkg::*;

module score_board #(
   parameter int NUM_PLAYERS = 2,
   parameter int DIGITS      = 2,
   parameter int WIN_SCORE   = 10
) (
   input  logic          clk,
   input  logic          clear_b,
   score_board_if.slave  bus
);

   localparam int              PW       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
   localparam int              SW       = DIGITS * 4;
   localparam int              MAX_VAL  = (10 ** DIGITS) - 1;
   localparam logic [SW-1:0]   MAX_BCD  = {DIGITS{4'h9}};
   localparam logic [SW-1:0]   WIN_BCD  = SW'(to_bcd(WIN_SCORE));
   localparam bit              WIN_ON   = (WIN_SCORE != 0);

   if (WIN_SCORE > MAX_VAL) begin : g_bad_win_score
      $error("score_board: WIN_SCORE larger than the largest representable score");
   end

   state_t                          state;
   logic [NUM_PLAYERS*SW-1:0]       scores_q;
   logic                            changed_q;
   logic                            over_q;
   logic [PW-1:0]                   winner_q;

   logic                            winner_ok;
   logic [PW-1:0]                   idx;
   logic [SW-1:0]                   cur_score;
   logic [SW-1:0]                   next_score;
   logic                            carry;
   logic [4:0]                      inc_res;

   // Winner's score plus one, BCD ripple carry, holding at all-nines
   always_comb begin
      winner_ok  = ({{(32-PW){1'b0}}, bus.round_winner} < 32'(NUM_PLAYERS));
      idx        = winner_ok ? bus.round_winner : '0;
      cur_score  = scores_q[int'(idx)*SW +: SW];
      next_score = cur_score;
      carry      = 1'b1;
      inc_res    = '0;
      for (int d = 0; d < DIGITS; d++) begin
         inc_res               = bcd_inc(cur_score[d*4 +: 4], carry);
         next_score[d*4 +: 4]  = inc_res[3:0];
         carry                 = inc_res[4];
      end
      if (cur_score == MAX_BCD)
         next_score = cur_score;
   end

   // Match FSM and score registers; new_match outranks a same-edge round result
   always_ff @(posedge clk) begin
      if (!clear_b) begin
         state     <= PLAY;
         scores_q  <= '0;
         changed_q <= 1'b0;
         over_q    <= 1'b0;
         winner_q  <= '0;
      end else begin
         changed_q <= 1'b0;
         if (bus.new_match) begin
            state    <= PLAY;
            scores_q <= '0;
            over_q   <= 1'b0;
            winner_q <= '0;
         end else begin
            case (state)
               PLAY: begin
                  if (bus.round_done && !bus.round_draw && winner_ok) begin
                     scores_q[int'(idx)*SW +: SW] <= next_score;
                     changed_q                    <= 1'b1;
                     if (WIN_ON && (next_score == WIN_BCD)) begin
                        state    <= MATCH_OVER;
                        over_q   <= 1'b1;
                        winner_q <= bus.round_winner;
                     end
                  end
               end
               MATCH_OVER: begin
                  state <= MATCH_OVER;
               end
               default: state <= PLAY;
            endcase
         end
      end
   end

   assign bus.scores_bcd    = scores_q;
   assign bus.score_changed = changed_q;
   assign bus.match_over    = over_q;
   assign bus.match_winner  = winner_q;

   for (genvar g = 0; g < NUM_PLAYERS*DIGITS; g++) begin : g_seg
      seg7_decoder u_seg (
         .bcd (scores_q[g*4 +: 4]),
         .seg (bus.hex_out[g*7 +: 7])
      );
   end

endmodule
